// File: rtl/hs_dpath_sfr_hs.sv
// Elastic fixed-latency pipeline: LATENCY shift stages with per-stage valid bits,
// a shared stage enable, and a 2-entry output skid FIFO that keeps s_ready off m_ready.
module hs_dpath_sfr_hs #(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           sreset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  DATA_TYPE                       s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output DATA_TYPE                       m_data,
    output logic                           ce,
    output logic [$clog2(LATENCY+3)-1:0]   in_flight,
    output logic                           busy
);

    localparam int             CW  = $clog2(LATENCY + 3);
    localparam logic [CW-1:0]  ONE = CW'(1);

    DATA_TYPE          r_data [LATENCY];
    logic [LATENCY-1:0] r_v;
    DATA_TYPE          r_fifo [2];
    logic [1:0]        r_cnt;
    logic [CW-1:0]     r_in_flight;

    logic w_ce;
    logic w_push;
    logic w_pop;
    logic w_in_xfer;
    logic w_out_xfer;

    // Stage enable and handshake qualifiers; only registers and sreset feed w_ce.
    always_comb begin
        w_ce       = !sreset && !(r_v[LATENCY-1] && (r_cnt == 2'd2));
        w_push     = w_ce && r_v[LATENCY-1];
        w_pop      = (r_cnt != 2'd0) && m_ready;
        w_in_xfer  = s_valid && w_ce;
        w_out_xfer = w_pop;
    end

    // Shift stages: all stages advance together on w_ce, bubbles included.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= RESET_VALUE;
            end
        end else if (w_ce) begin
            r_v[0]    <= s_valid;
            r_data[0] <= s_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_v[i]    <= r_v[i-1];
                r_data[i] <= r_data[i-1];
            end
        end else begin
            r_v <= r_v;
        end
    end

    // Skid FIFO: head lives in r_fifo[0]; a push with a concurrent pop at one entry replaces the head.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_cnt     <= 2'd0;
            r_fifo[0] <= RESET_VALUE;
            r_fifo[1] <= RESET_VALUE;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_fifo[r_cnt[0]] <= r_data[LATENCY-1];
                    r_cnt            <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo[0] <= r_fifo[1];
                    r_cnt     <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_fifo[0] <= r_data[LATENCY-1];
                    end else begin
                        r_fifo[0] <= r_fifo[1];
                        r_fifo[1] <= r_data[LATENCY-1];
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Beats accepted but not yet delivered; bounded by LATENCY+2 so it never wraps.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_in_flight <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_in_flight <= r_in_flight + ONE;
                2'b01:   r_in_flight <= r_in_flight - ONE;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Output mapping; every output derives from registers (plus sreset for the enable).
    always_comb begin
        ce        = w_ce;
        s_ready   = w_ce;
        m_valid   = (r_cnt != 2'd0);
        m_data    = r_fifo[0];
        in_flight = r_in_flight;
        busy      = (r_in_flight != '0);
    end

endmodule

// File: tb/tb_hs_dpath_sfr_hs.sv
// Scoreboard bench for hs_dpath_sfr_hs at LATENCY=3 with an 8-bit payload.
module tb_hs_dpath_sfr_hs;

    localparam int LAT = 3;
    localparam int CW  = $clog2(LAT + 3);
    typedef logic [7:0] byte_t;
    localparam byte_t RV = 8'h5A;

    logic          clk = 1'b0;
    logic          sreset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    byte_t         s_data = 8'h00;
    logic          m_valid;
    logic          m_ready = 1'b0;
    byte_t         m_data;
    logic          ce;
    logic [CW-1:0] in_flight;
    logic          busy;

    int    n_vec = 0;
    int    n_err = 0;
    byte_t sb_q[$];
    int    ts_q[$];
    int    cyc = 0;
    bit    lat_mode = 1'b0;
    int    n_out = 0;
    int    n_in = 0;
    int    peak = 0;

    always #5 clk = ~clk;

    hs_dpath_sfr_hs #(
        .DATA_TYPE   (byte_t),
        .RESET_VALUE (RV),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .sreset    (sreset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ce        (ce),
        .in_flight (in_flight),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the negedge, score the handshakes, check state after the edge.
    task automatic cycle(input logic sv, input byte_t sd, input logic mr);
        bit    in_x;
        bit    out_x;
        byte_t exp_d;
        int    t;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        in_x  = s_valid && s_ready;
        out_x = m_valid && m_ready;
        chk("ce_eq_s_ready", 32'(ce), 32'(s_ready));
        if (out_x) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                t     = ts_q.pop_front();
                chk("m_data", 32'(m_data), 32'(exp_d));
                if (lat_mode) chk("latency", 32'(cyc - t), 32'(LAT + 1));
            end
        end
        if (in_x) begin
            n_in++;
            sb_q.push_back(sd);
            ts_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("in_flight", 32'(in_flight), 32'(sb_q.size()));
        chk("busy", 32'(busy), 32'(sb_q.size() != 0));
        if (int'(in_flight) > peak) peak = int'(in_flight);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sreset  = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("s_ready_in_reset", 32'(s_ready), 32'd0);
        chk("ce_in_reset", 32'(ce), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'(RV));
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        ts_q.delete();
        @(negedge clk);
        sreset = 1'b0;
        #1;
        chk("s_ready_after_rst", 32'(s_ready), 32'd1);
        chk("ce_after_rst", 32'(ce), 32'd1);
    endtask

    initial begin
        int out0;
        int in0;
        do_reset();

        // Streaming, m_ready held high
        lat_mode = 1'b1;
        peak     = 0;
        out0     = n_out;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, byte_t'(i), 1'b1);
            chk("s_ready_stream", 32'(s_ready), 32'd1);
            if (i >= 5) begin
                chk("fifo_cnt_push_pop", 32'(dut.r_cnt), 32'd1);
                chk("in_flight_push_pop", 32'(in_flight), 32'd4);
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("stream_peak", 32'(peak), 32'd4);
        chk("stream_count", 32'(n_out - out0), 32'd8);
        lat_mode = 1'b0;

        // Backpressure: capacity LATENCY+2, then drain
        in0 = n_in;
        for (int i = 0; i < 8; i++) cycle(1'b1, byte_t'(8'h20 + i), 1'b0);
        chk("bp_accepted", 32'(n_in - in0), 32'd5);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_in_flight", 32'(in_flight), 32'd5);
        out0 = n_out;
        cycle(1'b0, 8'h00, 1'b1);
        chk("bp_s_ready_after_pop", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("bp_drained", 32'(n_out - out0), 32'd5);

        // Bubble between two beats with a mid-stream stall
        out0 = n_out;
        cycle(1'b1, 8'h0A, 1'b1);
        cycle(1'b0, 8'hEE, 1'b1);
        cycle(1'b1, 8'h0B, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'hEE, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'hEE, 1'b1);
        chk("bubble_count", 32'(n_out - out0), 32'd2);
        chk("bubble_idle", 32'(m_valid), 32'd0);

        // Reset with 4 beats in flight, then first beat latency
        for (int i = 0; i < 4; i++) cycle(1'b1, byte_t'(8'h40 + i), 1'b0);
        chk("pre_rst_in_flight", 32'(in_flight), 32'd4);
        do_reset();
        lat_mode = 1'b1;
        out0     = n_out;
        cycle(1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("post_rst_count", 32'(n_out - out0), 32'd1);
        lat_mode = 1'b0;

        // Random valid/ready at 50%
        peak = 0;
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 1)), byte_t'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("rand_peak_bound", 32'(peak <= LAT + 2), 32'd1);
        chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
